ot_op_controller: RTL
=====================

# ot_op_controller

Command-driven sequencer for the 8-lane AES operation unit (1024-bit datapath, fixed AES pipeline latency). It accepts one EXPAND or HASH command at a time, streams 1024-bit blocks into the unit, and drives the unit's `func`/`state`/`key` inputs so the output-side PRNG/XOR select matches each block as it leaves the pipeline. It emits results as an in-order valid/last stream. It sits between the OT protocol front-end and the operation unit.

## Interface
- `AES_LATENCY`, 29: cycles from the unit's `data_in` to its `data_out`; must equal the unit's parameter.
- `CNT_W`, 16: width of the block counters.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_func` in 1: 0 = EXPAND, 1 = HASH.
- `cmd_blocks` in CNT_W: number of blocks N.
- `cmd_prng` in CNT_W: EXPAND only; number of leading blocks run in PRNG mode. Clamped to N; ignored for HASH.
- `cmd_key` in 128: AES key for the command.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 1024: block input stream.
- `ou_func` out 1, `ou_state` out 2, `ou_key` out 128, `ou_data_in` out 1024: drive the operation unit.
- `ou_data_out` in 1024: operation unit result.
- `out_valid` out 1, `out_last` out 1, `out_data` out 1024: result stream. No backpressure; the consumer must take every beat.
- `busy` out 1: high in all states except IDLE.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch func, N, min(`cmd_prng`, N) and key; `ou_key` <= `cmd_key`.
  - Go to ISSUE if N>0, otherwise to DONE.
- ISSUE:
  - `in_ready`=1.
  - Each accepted beat: `ou_data_in` <= `in_data` (registered), and a tag {valid=1, prng, last} is pushed into the tag pipe.
  - `prng`=1 while the issued count is below the latched prng count. `last`=1 on beat N.
  - If no beat is accepted, `ou_data_in` <= 0 and an invalid tag is pushed (bubble).
  - After beat N, go to DRAIN.
- DRAIN:
  - `in_ready`=0; bubbles continue.
  - When the beat with `last` has been emitted on `out_valid`, go to DONE.
- DONE: lasts one cycle; `done`=1; return to IDLE.
- `ou_state` is combinational from the tag at the pipe's tail, because the unit applies its PRNG/XOR select at the output.
  - EXPAND: tail valid & prng → EXP_PRNG (1); tail valid & !prng → EXP_CAL (2); DONE → EXP_DONE (3); otherwise EXP_IDLE (0).
  - HASH: tail valid → HASH_CAL (1); DONE → HASH_DONE (2); otherwise HASH_IDLE (0).
- `ou_func` holds the latched func from acceptance until the next command.
- Output stage:
  - `out_valid` <= tail valid; `out_last` <= tail last; `out_data` <= `ou_data_out`.
  - `out_data` is zero when `out_valid`=0.
- The key is fixed for a whole command. No new command is accepted until the pipe has drained.
- Reset values: all outputs 0, FSM in IDLE, all tags invalid.
  - `cmd_ready` rises in the first cycle after `rst_n` returns high.
  - Reset mid-command discards every in-flight tag. Those blocks are never emitted, even though the unit's pipeline still holds their data.
- Counters are CNT_W bits with no wrap. N ≤ 2^CNT_W−1.

## Timing
- A beat accepted at clock edge k produces `ou_data_in` during cycles k..k+1. The unit's `data_out` is valid AES_LATENCY edges later.
- `out_valid` for that beat is high in the cycle after edge k+AES_LATENCY+1, i.e. latency AES_LATENCY+1 = 30 cycles.
- Output spacing and order exactly mirror input acceptance. Bubbles are preserved.
- `done` is high in the cycle after the `out_last` beat. `cmd_ready` is high the following cycle.
- N=0: `done` one cycle after acceptance, with no `out_valid`.
- A `cmd_valid` that arrives while `busy` is held off; `cmd_ready`=0 and there is no loss.

## Structure
- Package `ot_op_pkg` holds:
  - the func enum {EXPAND, HASH};
  - the expand states {EXP_IDLE, EXP_PRNG, EXP_CAL, EXP_DONE};
  - the hash states {HASH_IDLE, HASH_CAL, HASH_DONE};
  - the tag struct {valid, prng, last};
  - the controller FSM enum.
- Sub-module `ot_op_tag_pipe`: an AES_LATENCY-deep shift register of tags with synchronous clear.

## Test plan
- HASH, N=3, key K, back-to-back blocks A,B,C:
  - three `out_valid` beats at 30, 31 and 32 cycles after the first accept;
  - `out_data` = AES_K(x)^x for each block;
  - `ou_state`=1 while each block is at the tail;
  - `out_last` on C, then `done` plus `ou_state`=2 for one cycle.
- EXPAND, N=4, prng=1:
  - beat 0 = AES_K(x) with `ou_state`=1;
  - beats 1–3 = AES_K(x)^x with `ou_state`=2;
  - `ou_state`=3 in the DONE cycle.
- HASH, N=5, `in_valid` pattern 1,0,1,1,0,0,1,1: the `out_valid` pattern repeats the same gaps exactly, offset by 30 cycles.
- `cmd_blocks`=0: `done` in the cycle after acceptance; `out_valid` never asserts; `cmd_ready` is back high one cycle later.
- Accept 4 beats, assert `rst_n`=0 for one cycle at accept+10:
  - all outputs 0 in the next cycle;
  - no `out_valid` within the following 40 cycles;
  - a new command is accepted normally.
- `cmd_valid` held high through an active N=2 command:
  - `cmd_ready` stays low until DONE completes;
  - the second command is accepted on the IDLE cycle and its key appears on `ou_key` the next cycle.

Source files
------------

// File: rtl/ot_op_pkg.sv
// Shared types for the OT operation-unit controller: command function, unit
// select codes for both functions, the per-block tag and the controller FSM.
package ot_op_pkg;

  typedef enum logic {
    EXPAND = 1'b0,
    HASH   = 1'b1
  } func_e;

  typedef enum logic [1:0] {
    EXP_IDLE = 2'd0,
    EXP_PRNG = 2'd1,
    EXP_CAL  = 2'd2,
    EXP_DONE = 2'd3
  } exp_state_e;

  typedef enum logic [1:0] {
    HASH_IDLE = 2'd0,
    HASH_CAL  = 2'd1,
    HASH_DONE = 2'd2
  } hash_state_e;

  typedef struct packed {
    logic valid;
    logic prng;
    logic last;
  } tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  localparam int   TAG_W    = $bits(tag_t);
  localparam tag_t TAG_NONE = '{valid: 1'b0, prng: 1'b0, last: 1'b0};

endpackage

// File: rtl/ot_op_tag_pipe.sv
// Tag delay line that shadows the operation unit's pipeline so each block's
// tag reaches the tail in the same cycle as the block's result.
module ot_op_tag_pipe
  import ot_op_pkg::*;
#(
  parameter int DEPTH = 29
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stages [DEPTH];

  // NOTE: every stage is cleared (unlike a pure data delay line) because a
  // stale valid bit would emit a phantom beat; non-blocking assignments let
  // each stage take its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/ot_op_controller.sv
// Command sequencer for the 8-lane AES operation unit: issues blocks, tracks
// their tags through the AES latency and emits an in-order result stream.
module ot_op_controller
  import ot_op_pkg::*;
#(
  parameter int AES_LATENCY = 29,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_func,
  input  logic [CNT_W-1:0] cmd_blocks,
  input  logic [CNT_W-1:0] cmd_prng,
  input  logic [127:0]     cmd_key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1023:0]    in_data,
  output logic             ou_func,
  output logic [1:0]       ou_state,
  output logic [127:0]     ou_key,
  output logic [1023:0]    ou_data_in,
  input  logic [1023:0]    ou_data_out,
  output logic             out_valid,
  output logic             out_last,
  output logic [1023:0]    out_data,
  output logic             busy,
  output logic             done
);

  ctrl_state_e      state, state_nx;
  func_e            func_q;
  logic [CNT_W-1:0] n_q, prng_q, issued_q;
  logic             live_q;
  tag_t             issue_tag_q, issue_tag_nx, tail_tag;
  logic [TAG_W-1:0] tail_bits;
  logic             tag_clr, cmd_accept, beat_accept, beat_is_last;

  // live_q holds cmd_ready low for the cycle the reset edge leaves behind.
  assign cmd_ready    = live_q && (state == ST_IDLE);
  assign in_ready     = (state == ST_ISSUE);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign ou_func      = func_q;
  assign cmd_accept   = cmd_valid && cmd_ready;
  assign beat_accept  = in_valid && in_ready;
  assign beat_is_last = (issued_q == n_q - CNT_W'(1));
  assign tag_clr      = !rst_n;
  assign tail_tag     = tag_t'(tail_bits);

  // NOTE: every output of this block gets a default first so that no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nx     = state;
    issue_tag_nx = TAG_NONE;
    ou_state     = EXP_IDLE;

    case (state)
      ST_IDLE:  if (cmd_accept) state_nx = (cmd_blocks != '0) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (beat_accept && beat_is_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_last) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    if (beat_accept) begin
      issue_tag_nx.valid = 1'b1;
      issue_tag_nx.prng  = (issued_q < prng_q);
      issue_tag_nx.last  = beat_is_last;
    end

    // The unit applies its PRNG/XOR select at the output, so the select
    // follows the tag leaving the pipe rather than the one entering it.
    if (func_q == EXPAND) begin
      if (tail_tag.valid)      ou_state = tail_tag.prng ? EXP_PRNG : EXP_CAL;
      else if (state == ST_DONE) ou_state = EXP_DONE;
    end else begin
      if (tail_tag.valid)      ou_state = HASH_CAL;
      else if (state == ST_DONE) ou_state = HASH_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      live_q      <= 1'b0;
      func_q      <= EXPAND;
      n_q         <= '0;
      prng_q      <= '0;
      issued_q    <= '0;
      ou_key      <= '0;
      ou_data_in  <= '0;
      issue_tag_q <= TAG_NONE;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
    end else begin
      state  <= state_nx;
      live_q <= 1'b1;

      if (cmd_accept) begin
        func_q   <= func_e'(cmd_func);
        n_q      <= cmd_blocks;
        prng_q   <= cmd_func ? '0 : ((cmd_prng < cmd_blocks) ? cmd_prng : cmd_blocks);
        issued_q <= '0;
        ou_key   <= cmd_key;
      end else if (beat_accept) begin
        issued_q <= issued_q + CNT_W'(1);
      end

      ou_data_in  <= beat_accept ? in_data : '0;
      issue_tag_q <= issue_tag_nx;

      out_valid <= tail_tag.valid;
      out_last  <= tail_tag.last;
      out_data  <= tail_tag.valid ? ou_data_out : '0;
    end
  end

  // issue_tag_q is aligned with ou_data_in, so the pipe adds exactly the
  // unit's latency on top of it.
  ot_op_tag_pipe #(
    .DEPTH(AES_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .clr    (tag_clr),
    .tag_in (issue_tag_q),
    .tag_out(tail_bits)
  );

endmodule
